// File: rtl/latch_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer: control bundle + payload, valid/ready, flush.
// Latency 1 cycle when empty (or one held and draining); in_ready is registered from state only.
module latch_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [1:0]        r_occ;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_accept;
  logic              w_consume;

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_accept && !w_consume)      w_state_nxt = S_TWO;
          else if (!w_accept && w_consume) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_consume) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Handshake outputs are registered images of the next state, so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_TWO);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      r_occ       <= 2'(w_state_nxt);
      if (!flush) begin
        case (r_state)
          S_EMPTY: begin
            if (w_accept) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
            end
          end
          S_ONE: begin
            if (w_accept && w_consume) begin
              r_main_ctrl <= in_ctrl;
              r_main_data <= in_data;
            end else if (w_accept) begin
              r_skid_ctrl <= in_ctrl;
              r_skid_data <= in_data;
            end
          end
          S_TWO: begin
            if (w_consume) begin
              r_main_ctrl <= r_skid_ctrl;
              r_main_data <= r_skid_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ctrl  = r_out_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_latch_stage_skid.sv
// Directed vector table for the named corner cases, then random traffic against a queue-based model.
module tb_latch_stage_skid;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  latch_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy)
  );

  typedef struct {
    logic          r, f, v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          o;
    logic          ev, er;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic [1:0]    eo;
  } vec_t;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  logic [DW-1:0] m_last;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic add(input logic r, f, v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic o, ev, er, input logic [CW-1:0] ec,
                     input logic [DW-1:0] ed, input logic [1:0] eo);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.c = c; t.d = d; t.o = o;
    t.ev = ev; t.er = er; t.ec = ec; t.ed = ed; t.eo = eo;
    vecs.push_back(t);
  endtask

  // Reference: the stage is a FIFO of depth 2; out_data remembers the last head seen.
  task automatic model_step(input logic r, f, v, input logic [CW-1:0] c,
                            input logic [DW-1:0] d, input logic o);
    ent_t e;
    bit acc, con;
    if (r) begin
      mq.delete();
      m_last = '0;
    end else if (f) begin
      mq.delete();
    end else begin
      acc = v && (mq.size() < 2);
      con = o && (mq.size() > 0);
      if (con) void'(mq.pop_front());
      if (acc) begin
        e.c = c; e.d = d;
        mq.push_back(e);
      end
    end
    if (mq.size() > 0) m_last = mq[0].d;
  endtask

  task automatic drive(input logic r, f, v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input logic o);
    rst = r; flush = f; in_valid = v; in_ctrl = c; in_data = d; out_ready = o;
    @(posedge clk);
    model_step(r, f, v, c, d, o);
    #1;
  endtask

  task automatic compare(input string name, input logic ev, er, input logic [CW-1:0] ec,
                         input logic [DW-1:0] ed, input logic [1:0] eo);
    n_tests++;
    if (out_valid !== ev || in_ready !== er || out_ctrl !== ec ||
        out_data !== ed || occupancy !== eo) begin
      n_fail++;
      $display("FAIL %s: got valid=%0d ready=%0d ctrl=%0h data=%0h occ=%0d, want valid=%0d ready=%0d ctrl=%0h data=%0h occ=%0d",
               name, out_valid, in_ready, out_ctrl, out_data, occupancy, ev, er, ec, ed, eo);
    end
  endtask

  initial begin
    //   r  f  v  c  d      o    ev er ec ed     eo
    add(1, 0, 1, 3, 'h77, 0,   0, 1, 0, 'h00, 0);
    add(1, 0, 1, 3, 'h77, 0,   0, 1, 0, 'h00, 0);
    add(0, 0, 1, 3, 'hA5, 0,   1, 1, 3, 'hA5, 1);
    add(0, 0, 0, 0, 'h00, 1,   0, 1, 0, 'hA5, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 0, 1, 1, DW'(i), 1, 1, 1, 1, DW'(i), 1);
    add(0, 0, 0, 0, 'h00, 1,   0, 1, 0, 'h08, 0);
    add(0, 0, 1, 3, 'h40, 1,   1, 1, 3, 'h40, 1);
    add(0, 0, 0, 0, 'h00, 1,   0, 1, 0, 'h40, 0);
    add(0, 0, 1, 2, 'h10, 0,   1, 1, 2, 'h10, 1);
    add(0, 0, 1, 2, 'h11, 0,   1, 0, 2, 'h10, 2);
    add(0, 0, 1, 2, 'h12, 0,   1, 0, 2, 'h10, 2);
    add(0, 0, 1, 2, 'h12, 1,   1, 1, 2, 'h11, 1);
    add(0, 0, 1, 2, 'h12, 1,   1, 1, 2, 'h12, 1);
    add(0, 0, 0, 0, 'h00, 1,   0, 1, 0, 'h12, 0);
    add(0, 0, 1, 1, 'h20, 0,   1, 1, 1, 'h20, 1);
    add(0, 0, 1, 1, 'h21, 0,   1, 0, 1, 'h20, 2);
    add(0, 1, 1, 1, 'h22, 1,   0, 1, 0, 'h20, 0);
    add(0, 0, 0, 0, 'h00, 1,   0, 1, 0, 'h20, 0);
    add(0, 0, 1, 2, 'h24, 0,   1, 1, 2, 'h24, 1);
    add(0, 0, 1, 2, 'h25, 0,   1, 0, 2, 'h24, 2);
    add(1, 1, 1, 2, 'h26, 1,   0, 1, 0, 'h00, 0);
    add(0, 0, 1, 1, 'h30, 1,   1, 1, 1, 'h30, 1);
    add(0, 0, 0, 0, 'h00, 1,   0, 1, 0, 'h30, 0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    m_last = '0;
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].c, vecs[i].d, vecs[i].o);
      compare($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ec, vecs[i].ed, vecs[i].eo);
    end

    for (int k = 0; k < 3000; k++) begin
      logic r, f, v, o;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      ent_t h;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      c = CW'($urandom);
      d = $urandom;
      drive(r, f, v, c, d, o);
      if (mq.size() > 0) h = mq[0];
      else begin h.c = '0; h.d = '0; end
      compare($sformatf("rand%0d", k), mq.size() > 0, mq.size() < 2,
              (mq.size() > 0) ? h.c : CW'(0), m_last, 2'(mq.size()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
